// File: rtl/game_pkg.sv
// Shared constants and types for the game storage sequencer: directions,
// storage modes, reset positions, FSM encoding and the request record.
package game_pkg;

  localparam logic [7:0] DIR_UP    = 8'h00;
  localparam logic [7:0] DIR_DOWN  = 8'h01;
  localparam logic [7:0] DIR_LEFT  = 8'h03;
  localparam logic [7:0] DIR_RIGHT = 8'h07;

  localparam logic [3:0] MODE_RAM     = 4'b0000;
  localparam logic [3:0] MODE_T1      = 4'b0001;
  localparam logic [3:0] MODE_T1_PROJ = 4'b0011;
  localparam logic [3:0] MODE_T2      = 4'b0101;
  localparam logic [3:0] MODE_T2_PROJ = 4'b0111;

  localparam logic [7:0] POS_MIN = 8'h00;
  localparam logic [7:0] POS_MAX = 8'hFF;

  // Slot order inside a frame; bit 1 selects the player, bit 0 marks a projectile.
  localparam logic [1:0] SLOT_T1 = 2'd0;
  localparam logic [1:0] SLOT_P1 = 2'd1;
  localparam logic [1:0] SLOT_T2 = 2'd2;
  localparam logic [1:0] SLOT_P2 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_ISSUE,
    ST_WAIT,
    ST_LOAD,
    ST_CAPTURE,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       move;
    logic       fire;
    logic [7:0] dir;
  } req_t;

  function automatic logic [3:0] slot_mode(input logic [1:0] slot);
    case (slot)
      SLOT_T1: return MODE_T1;
      SLOT_P1: return MODE_T1_PROJ;
      SLOT_T2: return MODE_T2;
      default: return MODE_T2_PROJ;
    endcase
  endfunction

endpackage

// File: rtl/req_latch.sv
// Per-player request latch: holds move/fire pulses and the latest direction
// until a frame takes them; a pulse in the take cycle joins that frame.
module req_latch
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       move,
  input  logic [7:0] dir,
  input  logic       fire,
  input  logic       take,
  output req_t       req
);

  logic       move_q;
  logic       fire_q;
  logic [7:0] dir_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_q <= 1'b0;
      fire_q <= 1'b0;
      dir_q  <= DIR_UP;
    end else if (take) begin
      move_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      if (move) begin
        move_q <= 1'b1;
        dir_q  <= dir;
      end
      if (fire) fire_q <= 1'b1;
    end
  end

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    req.move = move_q | move;
    req.fire = fire_q | fire;
    req.dir  = move ? dir : dir_q;
  end

endmodule

// File: rtl/storage_sequencer.sv
// Frame sequencer for the game storage/ALU: services T1, P1, T2, P2 in order,
// tracks shadow positions/directions, projectile life, hits and scores.
module storage_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LAT     = 2,
  parameter int unsigned SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               p1_move,
  input  logic [7:0]         p1_dir,
  input  logic               p1_fire,
  input  logic               p2_move,
  input  logic [7:0]         p2_dir,
  input  logic               p2_fire,
  output logic [3:0]         st_mode,
  output logic               st_wren,
  output logic               st_load_out,
  output logic [7:0]         st_address,
  output logic [7:0]         st_data,
  input  logic [7:0]         st_q,
  output logic               busy,
  output logic               frame_done,
  output logic               hit1,
  output logic               hit2,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               overrun
);

  localparam logic [3:0]         WAIT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e           state;
  logic [1:0]       slot;
  logic [3:0]       wait_cnt;
  logic [3:0][7:0]  pos;
  logic [3:0][7:0]  dir;
  logic [1:0]       proj_active;
  req_t [1:0]       snap;

  req_t             req1;
  req_t             req2;
  logic             accept;

  logic             cur_player;
  logic             cur_is_proj;
  logic [1:0]       tank_slot;
  req_t             cur_req;
  logic             launch;
  logic             serviced;
  logic [7:0]       cur_addr;
  logic [7:0]       cur_dir;
  logic             last_slot;
  logic             hit1_now;
  logic             hit2_now;

  assign accept = (state == ST_IDLE) && tick;

  req_latch u_req1 (
    .clk   (clk),
    .reset (reset),
    .move  (p1_move),
    .dir   (p1_dir),
    .fire  (p1_fire),
    .take  (accept),
    .req   (req1)
  );

  req_latch u_req2 (
    .clk   (clk),
    .reset (reset),
    .move  (p2_move),
    .dir   (p2_dir),
    .fire  (p2_fire),
    .take  (accept),
    .req   (req2)
  );

  // A launching projectile starts from its owning tank's current shadow state.
  always_comb begin
    cur_player  = slot[1];
    cur_is_proj = slot[0];
    tank_slot   = {slot[1], 1'b0};
    cur_req     = snap[cur_player];
    launch      = cur_is_proj && cur_req.fire && !proj_active[cur_player];
    serviced    = cur_is_proj ? (proj_active[cur_player] || cur_req.fire) : cur_req.move;
    cur_addr    = launch ? pos[tank_slot] : pos[slot];
    if (!cur_is_proj)  cur_dir = cur_req.dir;
    else if (launch)   cur_dir = dir[tank_slot];
    else               cur_dir = dir[slot];
    last_slot   = (slot == SLOT_P2);
    hit1_now    = proj_active[0] && (pos[SLOT_P1] == pos[SLOT_T2]);
    hit2_now    = proj_active[1] && (pos[SLOT_P2] == pos[SLOT_T1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot        <= SLOT_T1;
      wait_cnt    <= 4'd0;
      // NOTE: the shadow tables are plain flops that define game state, so
      // they are reset like any other register.
      pos         <= {POS_MAX, POS_MAX, POS_MIN, POS_MIN};
      dir         <= {DIR_UP, DIR_UP, DIR_DOWN, DIR_DOWN};
      proj_active <= 2'b00;
      snap        <= '0;
      st_mode     <= MODE_RAM;
      st_wren     <= 1'b0;
      st_load_out <= 1'b0;
      st_address  <= 8'h00;
      st_data     <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      hit1        <= 1'b0;
      hit2        <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      overrun     <= 1'b0;
    end else begin
      st_wren     <= 1'b0;
      st_load_out <= 1'b0;
      frame_done  <= 1'b0;
      hit1        <= 1'b0;
      hit2        <= 1'b0;

      if (tick && state != ST_IDLE) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (tick) begin
            snap  <= {req2, req1};
            slot  <= SLOT_T1;
            busy  <= 1'b1;
            state <= ST_SLOT;
          end
        end

        ST_SLOT: begin
          if (serviced) begin
            if (launch) begin
              proj_active[cur_player] <= 1'b1;
              pos[slot]               <= cur_addr;
              dir[slot]               <= cur_dir;
            end
            st_mode    <= slot_mode(slot);
            st_wren    <= 1'b1;
            st_address <= cur_addr;
            st_data    <= cur_dir;
            state      <= ST_ISSUE;
          end else if (last_slot) begin
            state <= ST_CHECK;
          end else begin
            slot <= slot + 2'd1;
          end
        end

        ST_ISSUE: begin
          if (LAT > 1) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end else begin
            st_load_out <= 1'b1;
            state       <= ST_LOAD;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            st_load_out <= 1'b1;
            state       <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_LOAD: state <= ST_CAPTURE;

        // A projectile whose position did not change has hit the border.
        ST_CAPTURE: begin
          pos[slot] <= st_q;
          if (cur_is_proj) begin
            if (st_q == pos[slot]) proj_active[cur_player] <= 1'b0;
          end else begin
            dir[slot] <= cur_req.dir;
          end
          st_mode    <= MODE_RAM;
          st_address <= 8'h00;
          st_data    <= 8'h00;
          if (last_slot) begin
            state <= ST_CHECK;
          end else begin
            slot  <= slot + 2'd1;
            state <= ST_SLOT;
          end
        end

        ST_CHECK: begin
          if (hit1_now) begin
            proj_active[0] <= 1'b0;
            if (p1_score != SCORE_MAX) p1_score <= p1_score + SCORE_W'(1);
          end
          if (hit2_now) begin
            proj_active[1] <= 1'b0;
            if (p2_score != SCORE_MAX) p2_score <= p2_score + SCORE_W'(1);
          end
          hit1       <= hit1_now;
          hit2       <= hit2_now;
          frame_done <= 1'b1;
          state      <= ST_DONE;
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_sequencer.sv
// Directed bench for storage_sequencer: a table of frames with hand-computed
// storage accesses, frame lengths, hits and scores, plus overrun/reset cases.
module tb_storage_sequencer;

  localparam int LAT = 2;
  localparam int SW  = 4;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          p1_move;
  logic [7:0]    p1_dir;
  logic          p1_fire;
  logic          p2_move;
  logic [7:0]    p2_dir;
  logic          p2_fire;
  logic [3:0]    st_mode;
  logic          st_wren;
  logic          st_load_out;
  logic [7:0]    st_address;
  logic [7:0]    st_data;
  logic [7:0]    st_q;
  logic          busy;
  logic          frame_done;
  logic          hit1;
  logic          hit2;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;
  logic          overrun;

  // Storage stub: per-slot result bytes packed as {P2, T2, P1, T1}.
  logic [3:0][7:0] q_cur;

  int tests = 0;
  int fails = 0;

  storage_sequencer #(.LAT(LAT), .SCORE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .p1_move     (p1_move),
    .p1_dir      (p1_dir),
    .p1_fire     (p1_fire),
    .p2_move     (p2_move),
    .p2_dir      (p2_dir),
    .p2_fire     (p2_fire),
    .st_mode     (st_mode),
    .st_wren     (st_wren),
    .st_load_out (st_load_out),
    .st_address  (st_address),
    .st_data     (st_data),
    .st_q        (st_q),
    .busy        (busy),
    .frame_done  (frame_done),
    .hit1        (hit1),
    .hit2        (hit2),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    st_q = 8'h00;
    if (st_mode[0]) st_q = q_cur[st_mode[2:1]];
  end

  typedef struct {
    logic            p1m;
    logic [7:0]      p1d;
    logic            p1f;
    logic            p2m;
    logic [7:0]      p2d;
    logic            p2f;
    logic [3:0][7:0] q;
    int              cyc;
    logic [3:0]      svc;
    logic [3:0][7:0] addr;
    logic [3:0][7:0] data;
    logic            h1;
    logic            h2;
    int              s1;
    int              s2;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int mode_slot(input logic [3:0] m);
    case (m)
      4'b0001: return 0;
      4'b0011: return 1;
      4'b0101: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [34:0] all_outs();
    return {st_mode, st_wren, st_load_out, st_address, st_data, busy, frame_done,
            hit1, hit2, p1_score, p2_score, overrun};
  endfunction

  task automatic clear_inputs();
    tick    = 1'b0;
    p1_move = 1'b0;
    p1_dir  = 8'h00;
    p1_fire = 1'b0;
    p2_move = 1'b0;
    p2_dir  = 8'h00;
    p2_fire = 1'b0;
  endtask

  // Requests are driven together with the tick, so they belong to this frame.
  task automatic apply_vec(input vec_t v, input string tag);
    int              n;
    int              k;
    bit              done;
    logic [3:0]      seen;
    logic [3:0][7:0] addr_seen;
    logic [3:0][7:0] data_seen;
    int              wren_cnt;
    int              load_cnt;
    int              lat_bad;
    int              bad_mode;
    int              last_wren;
    logic            h1;
    logic            h2;
    logic [SW-1:0]   s1;
    logic [SW-1:0]   s2;
    n = 0; done = 0; seen = '0; addr_seen = '0; data_seen = '0;
    wren_cnt = 0; load_cnt = 0; lat_bad = 0; bad_mode = 0; last_wren = 0;
    h1 = 0; h2 = 0; s1 = '0; s2 = '0;
    q_cur   = v.q;
    p1_move = v.p1m; p1_dir = v.p1d; p1_fire = v.p1f;
    p2_move = v.p2m; p2_dir = v.p2d; p2_fire = v.p2f;
    tick    = 1'b1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) clear_inputs();
      if (st_wren) begin
        wren_cnt++;
        last_wren = n;
        k = mode_slot(st_mode);
        if (k < 0) bad_mode++;
        else begin
          seen[k]      = 1'b1;
          addr_seen[k] = st_address;
          data_seen[k] = st_data;
        end
      end
      if (st_load_out) begin
        load_cnt++;
        if (n - last_wren != LAT) lat_bad++;
      end
      if (frame_done) begin
        done = 1;
        h1 = hit1; h2 = hit2; s1 = p1_score; s2 = p2_score;
      end
    end
    check({tag, ".cycle"}, done ? n + 1 : 0, v.cyc);
    check({tag, ".serviced"}, seen, v.svc);
    check({tag, ".wren_count"}, wren_cnt, $countones(v.svc));
    check({tag, ".load_count"}, load_cnt, $countones(v.svc));
    check({tag, ".load_latency_errors"}, lat_bad, 0);
    check({tag, ".bad_mode"}, bad_mode, 0);
    for (int j = 0; j < 4; j++) begin
      if (v.svc[j]) begin
        check($sformatf("%s.addr%0d", tag, j), addr_seen[j], v.addr[j]);
        check($sformatf("%s.data%0d", tag, j), data_seen[j], v.data[j]);
      end
    end
    check({tag, ".hit1"}, h1, v.h1);
    check({tag, ".hit2"}, h2, v.h2);
    check({tag, ".p1_score"}, s1, v.s1);
    check({tag, ".p2_score"}, s2, v.s2);
    @(negedge clk);
    check({tag, ".busy_after"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   done;
    int   wr;
    int   fd;
    vec_t sv;

    // Fields: p1m p1d p1f p2m p2d p2f | q{P2,T2,P1,T1} cyc svc addr data h1 h2 s1 s2
    // cyc counts the tick cycle as 1: 7 + 4 per serviced slot at LAT=2.
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_00_10, 11, 4'b0001,
                 32'h00_00_00_00, 32'h00_00_00_01, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_00_00, 7, 4'b0000,
                 32'h00_00_00_00, 32'h00_00_00_00, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 32'h00_00_20_00, 11, 4'b0010,
                 32'h00_00_10_00, 32'h00_00_01_00, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_30_11, 15, 4'b0011,
                 32'h00_00_20_10, 32'h00_00_01_01, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 32'h00_FE_FE_00, 15, 4'b0110,
                 32'h00_FF_30_00, 32'h00_03_01_00, 1'b1, 1'b0, 1, 0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 32'hFE_00_F0_00, 15, 4'b1010,
                 32'hFE_00_11_00, 32'h03_00_01_00, 1'b0, 1'b0, 1, 0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_F0_00, 11, 4'b0010,
                 32'h00_00_F0_00, 32'h00_00_01_00, 1'b0, 1'b0, 1, 0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_00_00, 7, 4'b0000,
                 32'h00_00_00_00, 32'h00_00_00_00, 1'b0, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h00, 1'b1, 32'h12_EE_13_12, 23, 4'b1111,
                 32'hEE_FE_12_11, 32'h00_00_07_07, 1'b0, 1'b1, 1, 1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 32'h12_00_EE_00, 15, 4'b1010,
                 32'hEE_00_13_00, 32'h00_00_07_00, 1'b1, 1'b1, 2, 2};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 32'h00_FF_00_00, 11, 4'b0100,
                 32'h00_EE_00_00, 32'h00_01_00_00, 1'b0, 1'b0, 2, 2};

    clear_inputs();
    q_cur = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.outputs_zero", all_outs(), 35'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // P1 launched from T1=0x12 lands on T2=0xFF every frame; score saturates at 15.
    for (int k = 0; k < 14; k++) begin
      sv = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 32'h00_00_FF_00, 11, 4'b0010,
             32'h00_00_12_00, 32'h00_00_07_00, 1'b1, 1'b0, 0, 2};
      sv.s1 = (3 + k > 15) ? 15 : 3 + k;
      apply_vec(sv, $sformatf("sat%0d", k));
    end

    // Second tick in cycle 3 is dropped; moves during the frame wait for the next one.
    q_cur = 32'h00_00_00_40;
    tick  = 1'b1;
    n = 0; done = 0; wr = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      tick    = (n == 2);
      p1_move = (n == 2) || (n == 3);
      p1_dir  = (n == 2) ? 8'h03 : 8'h07;
      if (st_wren) wr++;
      if (frame_done) done = 1;
    end
    clear_inputs();
    check("ovr.cycle", done ? n + 1 : 0, 7);
    check("ovr.wren_count", wr, 0);
    check("ovr.flag", overrun, 1);
    @(negedge clk);
    check("ovr.busy_after", busy, 0);
    sv = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'h00_00_00_40, 11, 4'b0001,
           32'h00_00_00_12, 32'h00_00_00_07, 1'b0, 1'b0, 15, 2};
    apply_vec(sv, "ovr_next");
    check("ovr.sticky", overrun, 1);

    // Reset during WAIT aborts the frame and restores the shadow state.
    q_cur   = 32'h00_00_00_99;
    p1_move = 1'b1;
    p1_dir  = 8'h03;
    tick    = 1'b1;
    n = 0; wr = 0;
    while (wr == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) clear_inputs();
      if (st_wren) wr = 1;
    end
    check("rst.issue_seen", wr, 1);
    @(negedge clk);
    check("rst.wait_mode", {st_wren, st_mode}, {1'b0, 4'b0001});
    reset = 1'b1;
    @(negedge clk);
    check("rst.outputs_zero", all_outs(), 35'd0);
    reset = 1'b0;
    fd = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    check("rst.no_frame_done", fd, 0);
    sv = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 32'hFF_00_06_05, 19, 4'b1011,
           32'hFF_00_05_00, 32'h00_00_01_01, 1'b0, 1'b0, 0, 0};
    apply_vec(sv, "post_reset");
    check("post_reset.overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
